ppu_frame_writer: RTL and testbench
===================================

Name: ppu_frame_writer

Overview:
- Upstream stage of vga_fb. Stands in for the PPU pixel pipeline until the real PPU is integrated.
- Walks NES scanline timing and issues one 6-bit palette-index write per visible dot on the vga_fb PPU-side write port (ppu_ptr_x, ppu_ptr_y, ppu_DI).
- Generates test patterns and exposes vblank and frame handshakes, so vga_fb and vga_out can be exercised without a hand-built ROM array.

Parameters:
- DOTS_PER_LINE, 341, total PPU dots per scanline (256 visible + hblank)
- LINES_PER_FRAME, 262, total scanlines per frame (240 visible + post-render + vblank + pre-render)
- SOLID_COLOR, 6'h21, palette index used by pattern 0

Ports:
- ppu_clk  in  1  PPU clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; begins frame generation from IDLE
- cont  in  1  1 = free-run frames; 0 = stop after the current frame
- pattern_sel  in  2  pattern select; latched at frame start only
- stall  in  1  back-pressure from frame buffer; freezes the pipeline
- ppu_ptr_x  out  8  write column 0..255
- ppu_ptr_y  out  8  write row 0..239
- ppu_DI  out  6  palette index to write
- ppu_we  out  1  write strobe; also drives vga_fb CS
- vblank  out  1  high for scanlines 241..260 inclusive
- frame_done  out  1  one-cycle pulse coincident with the write of pixel (255,239)
- frame_cnt  out  8  completed-frame counter; wraps 255 -> 0
- busy  out  1  high in RUN state

Behaviour:
- Reset: rst is synchronous, active-high; clock is ppu_clk. All outputs 0, state IDLE, dot = 0, line = 0, latched pattern = 0. Reset asserted mid-frame aborts immediately: no further ppu_we, no frame_done, frame_cnt returns to 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when start = 1. pattern_sel is latched in the same cycle; dot = 0, line = 0.
  - RUN -> RUN at end of frame (dot 340, line 261, not stalled) when cont = 1. pattern_sel is re-latched; frame_cnt increments.
  - RUN -> IDLE at end of frame when cont = 0. frame_cnt increments.
  - start is ignored while in RUN.
- Counters: dot counts 0..340, then wraps to 0 and line increments; line counts 0..261, then wraps to 0. The counters point to the next dot to emit.
- Output pipeline (registered, 1-cycle latency). If in cycle n state = RUN, stall = 0, dot < 256 and line < 240, then in cycle n+1:
  - ppu_we = 1
  - ppu_ptr_x = dot[7:0]
  - ppu_ptr_y = line[7:0]
  - ppu_DI = pattern(dot, line)
  Otherwise ppu_we = 0 in n+1, and ptr/DI hold their previous values.
- Stall: when stall = 1 in cycle n, the counters and FSM hold and ppu_we = 0 in n+1. The held dot is emitted in the cycle after stall drops, so no pixel is lost or duplicated. A stall that spans end of frame delays both the transition and the frame_cnt increment.
- vblank: registered from line; asserted when 241 <= line <= 260 while in RUN; 0 in IDLE.
- frame_done: asserted in the same cycle as the ppu_we write of (255,239).
- Patterns, with x = dot[7:0] and y = line[7:0]:
  - 0: SOLID_COLOR
  - 1: colour bars indexed by x[7:5] over {30,28,2C,2A,24,21,26,0F} hex
  - 2: checkerboard, (x[3]^y[3]) ? 6'h30 : 6'h0F
  - 3: gradient {y[7:6], x[7:4]}
- Frame timing: 341 x 262 = 89342 unstalled cycles per frame, containing exactly 61440 writes.

Decomposition:
- Package nes_video_pkg:
  - H_VISIBLE = 256, V_VISIBLE = 240, VBLANK_FIRST = 241, VBLANK_LAST = 260
  - pattern_e enum {PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_GRAD}
  - the 8-entry bar colour constant array
  - state_e enum {IDLE, RUN}
- One combinational sub-module, ppu_pattern_lut: inputs (pattern_e, x, y), output 6-bit index. Reused later by the PPU debug overlay.

Test Plan:
1. Reset, then start = 1 for 1 cycle, cont = 0, pattern_sel = 0 -> first ppu_we 2 cycles after start, at (0,0) with DI = 6'h21; exactly 61440 writes; busy falls 89342 cycles after entering RUN; frame_cnt = 1.
2. pattern_sel = 1, scoreboard against a model of vga_fb -> pixel (40,10) = 6'h28, (255,239) = 6'h0F; frame_done pulses exactly once, in the same cycle as the (255,239) write.
3. Random stall (30% duty) during the visible region -> the write sequence matches the unstalled run exactly (no gaps, no duplicates); ppu_we = 0 in every cycle following a stall cycle.
4. cont = 1 for 3 frames; pattern_sel changed mid-frame 1 -> the change takes effect only from frame 2's first write; frame_cnt reads 1, 2, 3 at the frame boundaries; vblank high for 20 x 341 cycles per frame.
5. rst asserted at line 100, dot 50 -> next cycle all outputs 0 and state IDLE; no frame_done; start afterwards restarts at (0,0).
6. 256 frames with cont = 1 -> frame_cnt wraps 255 -> 0.

Source files
------------

// File: rtl/nes_video_pkg.sv
// NES raster constants and shared types for the PPU-side video path.
// Consumed by the stand-in frame writer and, later, the PPU debug overlay.
package nes_video_pkg;

    localparam int H_VISIBLE    = 256;
    localparam int V_VISIBLE    = 240;
    localparam int VBLANK_FIRST = 241;
    localparam int VBLANK_LAST  = 260;

    typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_GRAD} pattern_e;

    typedef enum logic {IDLE, RUN} state_e;

    // Bar colours left to right, one bar per 32 columns.
    localparam logic [5:0] BAR_COLORS [0:7] = '{
        6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h21, 6'h26, 6'h0F
    };

endpackage

// File: rtl/ppu_pattern_lut.sv
// Combinational test-pattern generator: maps (pattern, x, y) to a 6-bit palette index.
module ppu_pattern_lut
    import nes_video_pkg::*;
#(
    parameter logic [5:0] SOLID_COLOR = 6'h21
) (
    input  pattern_e   i_pattern,
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    output logic [5:0] o_index
);

    always_comb begin
        o_index = SOLID_COLOR;
        case (i_pattern)
            PAT_SOLID: o_index = SOLID_COLOR;
            PAT_BARS:  o_index = BAR_COLORS[i_x[7:5]];
            PAT_CHECK: o_index = (i_x[3] ^ i_y[3]) ? 6'h30 : 6'h0F;
            PAT_GRAD:  o_index = {i_y[7:6], i_x[7:4]};
            default:   o_index = SOLID_COLOR;
        endcase
    end

endmodule

// File: rtl/ppu_frame_writer.sv
// Stand-in PPU: walks NES dot/line timing and writes one test-pattern pixel per
// visible dot into the vga_fb PPU-side port, with vblank and frame handshakes.
module ppu_frame_writer
    import nes_video_pkg::*;
#(
    parameter int         DOTS_PER_LINE   = 341,
    parameter int         LINES_PER_FRAME = 262,
    parameter logic [5:0] SOLID_COLOR     = 6'h21,
    parameter int         H_ACTIVE        = H_VISIBLE,
    parameter int         V_ACTIVE        = V_VISIBLE,
    parameter int         VBL_FIRST       = VBLANK_FIRST,
    parameter int         VBL_LAST        = VBLANK_LAST
) (
    input  logic       ppu_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [1:0] pattern_sel,
    input  logic       stall,
    output logic [7:0] ppu_ptr_x,
    output logic [7:0] ppu_ptr_y,
    output logic [5:0] ppu_DI,
    output logic       ppu_we,
    output logic       vblank,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       busy,
    output state_e     o_dbg_state
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);

    state_e     r_state, w_state_nxt;
    logic [8:0] r_dot, r_line;
    pattern_e   r_pat;
    logic [7:0] r_frame_cnt;
    logic       r_we, r_vblank, r_frame_done;
    logic [7:0] r_x, r_y;
    logic [5:0] r_di;
    logic       w_start_frame, w_adv, w_eol, w_eof;
    logic       w_emit, w_last_px, w_vbl_line;
    logic [5:0] w_pix;

    // Handshake: stall is a level back-pressure; while high in cycle n nothing
    // advances and no write is issued in n+1, so the held dot goes out once stall drops.
    assign w_start_frame = (r_state == IDLE) && start;
    assign w_adv         = (r_state == RUN) && !stall;
    assign w_eol         = (r_dot == DOT_LAST);
    assign w_eof         = w_eol && (r_line == LINE_LAST);

    always_ff @(posedge ppu_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_adv && w_eof && !cont) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_emit     = w_adv && (r_dot < 9'(H_ACTIVE)) && (r_line < 9'(V_ACTIVE));
        w_last_px  = w_emit && (r_dot == 9'(H_ACTIVE - 1)) && (r_line == 9'(V_ACTIVE - 1));
        w_vbl_line = (r_state == RUN) && (r_line >= 9'(VBL_FIRST)) && (r_line <= 9'(VBL_LAST));
    end

    // Counters point at the next dot to emit; pattern is only sampled at a frame start.
    always_ff @(posedge ppu_clk) begin
        if (rst) begin
            r_dot       <= '0;
            r_line      <= '0;
            r_pat       <= PAT_SOLID;
            r_frame_cnt <= '0;
        end else if (w_start_frame) begin
            r_dot  <= '0;
            r_line <= '0;
            r_pat  <= pattern_e'(pattern_sel);
        end else if (w_adv) begin
            if (w_eol) begin
                r_dot  <= '0;
                r_line <= w_eof ? 9'd0 : r_line + 9'd1;
            end else begin
                r_dot <= r_dot + 9'd1;
            end
            if (w_eof) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (cont) r_pat <= pattern_e'(pattern_sel);
            end
        end
    end

    ppu_pattern_lut #(
        .SOLID_COLOR (SOLID_COLOR)
    ) u_lut (
        .i_pattern (r_pat),
        .i_x       (r_dot[7:0]),
        .i_y       (r_line[7:0]),
        .o_index   (w_pix)
    );

    always_ff @(posedge ppu_clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_vblank     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_di         <= '0;
        end else begin
            r_we         <= w_emit;
            r_frame_done <= w_last_px;
            r_vblank     <= w_vbl_line;
            if (w_emit) begin
                r_x  <= r_dot[7:0];
                r_y  <= r_line[7:0];
                r_di <= w_pix;
            end
        end
    end

    assign ppu_ptr_x   = r_x;
    assign ppu_ptr_y   = r_y;
    assign ppu_DI      = r_di;
    assign ppu_we      = r_we;
    assign vblank      = r_vblank;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = (r_state == RUN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Bench for ppu_frame_writer: a shortened raster (256 x 12 visible) for pixel-level checks
// and a tiny raster instance for the 256-frame frame_cnt wrap.
`timescale 1ns/1ps
module tb_ppu_frame_writer;
    import nes_video_pkg::*;

    localparam int DOTS   = 260;
    localparam int LINES  = 16;
    localparam int HV     = 256;
    localparam int VV     = 12;
    localparam int VB0    = 13;
    localparam int VB1    = 14;
    localparam int FRAME  = DOTS * LINES;
    localparam int WRITES = HV * VV;
    localparam int T_DOTS  = 6;
    localparam int T_LINES = 5;
    localparam int T_HV    = 4;
    localparam int T_VV    = 2;
    localparam int T_FRAME = T_DOTS * T_LINES;
    localparam int W = 23;

    // ---------------- clock / reset / DUT ----------------
    logic ppu_clk = 1'b0;
    always #5 ppu_clk = ~ppu_clk;

    logic       rst, start, cont, stall;
    logic [1:0] pattern_sel;
    logic [7:0] ppu_ptr_x, ppu_ptr_y, frame_cnt;
    logic [5:0] ppu_DI;
    logic       ppu_we, vblank, frame_done, busy;
    state_e     dbg_state;

    logic       t_start, t_cont;
    logic [1:0] t_pat;
    logic [7:0] t_x, t_y, t_frame_cnt;
    logic [5:0] t_di;
    logic       t_we, t_vblank, t_frame_done, t_busy;
    state_e     t_state;

    ppu_frame_writer #(
        .DOTS_PER_LINE (DOTS), .LINES_PER_FRAME (LINES), .SOLID_COLOR (6'h21),
        .H_ACTIVE (HV), .V_ACTIVE (VV), .VBL_FIRST (VB0), .VBL_LAST (VB1)
    ) u_dut (
        .ppu_clk (ppu_clk), .rst (rst), .start (start), .cont (cont),
        .pattern_sel (pattern_sel), .stall (stall),
        .ppu_ptr_x (ppu_ptr_x), .ppu_ptr_y (ppu_ptr_y), .ppu_DI (ppu_DI), .ppu_we (ppu_we),
        .vblank (vblank), .frame_done (frame_done), .frame_cnt (frame_cnt), .busy (busy),
        .o_dbg_state (dbg_state)
    );

    ppu_frame_writer #(
        .DOTS_PER_LINE (T_DOTS), .LINES_PER_FRAME (T_LINES), .SOLID_COLOR (6'h21),
        .H_ACTIVE (T_HV), .V_ACTIVE (T_VV), .VBL_FIRST (3), .VBL_LAST (3)
    ) u_wrap (
        .ppu_clk (ppu_clk), .rst (rst), .start (t_start), .cont (t_cont),
        .pattern_sel (t_pat), .stall (1'b0),
        .ppu_ptr_x (t_x), .ppu_ptr_y (t_y), .ppu_DI (t_di), .ppu_we (t_we),
        .vblank (t_vblank), .frame_done (t_frame_done), .frame_cnt (t_frame_cnt), .busy (t_busy),
        .o_dbg_state (t_state)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- monitor / vga_fb model ----------------
    logic [W-1:0] wr_q[$];
    logic [W-1:0] exp_q[$];
    logic [7:0]   cnt_q[$];
    logic [5:0]   fb [0:VV-1][0:HV-1];
    int fd_cnt, fd_bad, we_after_stall, vblank_cyc, busy_cyc, stall_run, t_fd_cnt, t_wr_cnt;
    logic prev_stall = 1'b0;

    always @(negedge ppu_clk) begin
        if (ppu_we) begin
            wr_q.push_back({ppu_ptr_x, ppu_ptr_y, ppu_DI, frame_done});
            if (int'(ppu_ptr_y) < VV) fb[int'(ppu_ptr_y)][int'(ppu_ptr_x)] = ppu_DI;
            if (ppu_ptr_x == 8'd0 && ppu_ptr_y == 8'd0) cnt_q.push_back(frame_cnt);
        end
        if (frame_done) fd_cnt++;
        if (frame_done && !ppu_we) fd_bad++;
        if (prev_stall && ppu_we) we_after_stall++;
        if (vblank) vblank_cyc++;
        if (busy) busy_cyc++;
        if (busy && stall) stall_run++;
        prev_stall = stall;
        if (t_frame_done) t_fd_cnt++;
        if (t_we) t_wr_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] pat_ref(input int p, input int x, input int y);
        logic [5:0] bars [0:7];
        bars = '{6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h21, 6'h26, 6'h0F};
        case (p)
            0:       return 6'h21;
            1:       return bars[x / 32];
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 6'h30 : 6'h0F;
            default: return 6'((y / 64) * 16 + x / 16);
        endcase
    endfunction

    task automatic add_frame_exp(input int p);
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                exp_q.push_back({8'(x), 8'(y), pat_ref(p, x, y), 1'(x == HV - 1 && y == VV - 1)});
    endtask

    function automatic int first_diff();
        int n;
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (wr_q[i] !== exp_q[i]) return i;
        if (wr_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic void report_diff(input string name, input int idx);
        logic [W-1:0] g, e;
        g = (idx < wr_q.size()) ? wr_q[idx] : '1;
        e = (idx < exp_q.size()) ? exp_q[idx] : '1;
        $display("FAIL %s: write #%0d got {x,y,di,fd}=%h required %h (writes got %0d required %0d)",
                 name, idx, g, e, wr_q.size(), exp_q.size());
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ppu_clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete(); exp_q.delete(); cnt_q.delete();
        fd_cnt = 0; fd_bad = 0; we_after_stall = 0; vblank_cyc = 0;
        busy_cyc = 0; stall_run = 0; t_fd_cnt = 0; t_wr_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cont = 1'b0; stall = 1'b0; pattern_sel = 2'd0;
        t_start = 1'b0; t_cont = 1'b0; t_pat = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge ppu_clk);
        checks++;
        if (ppu_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", ppu_we); end
        checks++;
        if ({ppu_ptr_x, ppu_ptr_y, ppu_DI} !== 22'd0) begin
            errors++; $display("FAIL reset_ptr: got %h/%h/%h required 0", ppu_ptr_x, ppu_ptr_y, ppu_DI);
        end
        checks++;
        if ({vblank, frame_done, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got vblank/fd/busy=%b required 000", {vblank, frame_done, busy});
        end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        checks++;
        if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
    endtask

    task automatic test_solid_frame();
        do_reset();
        clear_mon();
        cont = 1'b0; pattern_sel = 2'd0; start = 1'b1;
        @(negedge ppu_clk);
        checks++;
        if (ppu_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_cycle: got we=%b busy=%b required 0 0", ppu_we, busy);
        end
        tick();
        start = 1'b0;
        @(negedge ppu_clk);
        checks++;
        if (busy !== 1'b1 || ppu_we !== 1'b0) begin
            errors++; $display("FAIL run_entry: got busy=%b we=%b required 1 0", busy, ppu_we);
        end
        tick();
        @(negedge ppu_clk);
        checks++;
        if ({ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI} !== {1'b1, 8'd0, 8'd0, 6'h21}) begin
            errors++; $display("FAIL first_write: got we=%b (%0d,%0d) di=%h required 1 (0,0) 21",
                               ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI);
        end
        tick();
        wait_idle(FRAME + 100, "solid_end");
        checks++;
        if (wr_q.size() != WRITES) begin errors++; $display("FAIL solid_count: got %0d required %0d", wr_q.size(), WRITES); end
        checks++;
        if (busy_cyc != FRAME) begin errors++; $display("FAIL solid_busy: got %0d required %0d", busy_cyc, FRAME); end
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL solid_frame_cnt: got %0d required 1", frame_cnt); end
        add_frame_exp(0);
        checks++;
        if (first_diff() != -1) begin errors++; report_diff("solid_seq", first_diff()); end
    endtask

    task automatic test_bars_fb();
        logic [W-1:0] last_w;
        do_reset();
        clear_mon();
        for (int y = 0; y < VV; y++) for (int x = 0; x < HV; x++) fb[y][x] = 6'h3F;
        cont = 1'b0; pattern_sel = 2'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        wait_idle(FRAME + 100, "bars_end");
        checks++;
        if (fb[10][40] !== 6'h28) begin errors++; $display("FAIL bars_px_40_10: got %h required 28", fb[10][40]); end
        checks++;
        if (fb[VV-1][HV-1] !== 6'h0F) begin errors++; $display("FAIL bars_px_last: got %h required 0F", fb[VV-1][HV-1]); end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL bars_fd_count: got %0d required 1", fd_cnt); end
        checks++;
        if (fd_bad != 0) begin errors++; $display("FAIL bars_fd_no_we: got %0d required 0", fd_bad); end
        last_w = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : '0;
        checks++;
        if (last_w !== {8'(HV - 1), 8'(VV - 1), 6'h0F, 1'b1}) begin
            errors++; $display("FAIL bars_fd_on_last: got %h required %h", last_w, {8'(HV - 1), 8'(VV - 1), 6'h0F, 1'b1});
        end
        add_frame_exp(1);
        checks++;
        if (first_diff() != -1) begin errors++; report_diff("bars_seq", first_diff()); end
    endtask

    task automatic test_stall();
        int p, n;
        do_reset();
        clear_mon();
        p = $urandom_range(0, 3);
        cont = 1'b0; pattern_sel = 2'(p); start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        while (n < 3 * FRAME) begin
            stall = ($urandom_range(0, 99) < 30);
            tick();
            n++;
            if (busy !== 1'b1) break;
        end
        stall = 1'b0;
        wait_idle(FRAME, "stall_end");
        add_frame_exp(p);
        checks++;
        if (first_diff() != -1) begin errors++; report_diff("stall_seq", first_diff()); end
        checks++;
        if (we_after_stall != 0) begin errors++; $display("FAIL stall_we_after: got %0d writes after stall required 0", we_after_stall); end
        checks++;
        if (busy_cyc != FRAME + stall_run) begin
            errors++; $display("FAIL stall_busy: got %0d required %0d", busy_cyc, FRAME + stall_run);
        end
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL stall_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

    task automatic test_cont_frames();
        int pa, pb, n;
        do_reset();
        clear_mon();
        pa = $urandom_range(0, 3);
        pb = (pa + $urandom_range(1, 3)) % 4;
        cont = 1'b1; pattern_sel = 2'(pa); start = 1'b1;
        tick(); start = 1'b0;
        repeat (FRAME / 2) tick();
        pattern_sel = 2'(pb);
        n = 0;
        while (frame_cnt !== 8'd2 && n < 2 * FRAME) begin tick(); n++; end
        checks++;
        if (frame_cnt !== 8'd2) begin errors++; $display("FAIL cont_reach_f3: frame_cnt=%0d required 2", frame_cnt); end
        cont = 1'b0;
        wait_idle(2 * FRAME, "cont_end");
        add_frame_exp(pa); add_frame_exp(pb); add_frame_exp(pb);
        checks++;
        if (first_diff() != -1) begin errors++; report_diff("cont_seq", first_diff()); end
        checks++;
        if (cnt_q.size() != 3 || cnt_q[0] !== 8'd0 || cnt_q[1] !== 8'd1 || cnt_q[2] !== 8'd2) begin
            errors++; $display("FAIL cont_cnt_at_starts: got %0d entries, first three %p required 0,1,2", cnt_q.size(), cnt_q);
        end
        checks++;
        if (frame_cnt !== 8'd3) begin errors++; $display("FAIL cont_frame_cnt: got %0d required 3", frame_cnt); end
        checks++;
        if (vblank_cyc != 3 * (VB1 - VB0 + 1) * DOTS) begin
            errors++; $display("FAIL cont_vblank: got %0d required %0d", vblank_cyc, 3 * (VB1 - VB0 + 1) * DOTS);
        end
        checks++;
        if (busy_cyc != 3 * FRAME) begin errors++; $display("FAIL cont_busy: got %0d required %0d", busy_cyc, 3 * FRAME); end
        checks++;
        if (fd_cnt != 3) begin errors++; $display("FAIL cont_fd_count: got %0d required 3", fd_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit found;
        clear_mon();
        pattern_sel = 2'd2; cont = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        n = 0; found = 1'b0;
        while (n < FRAME) begin
            @(negedge ppu_clk);
            if (ppu_we === 1'b1 && ppu_ptr_x == 8'd49 && ppu_ptr_y == 8'd10) begin found = 1'b1; break; end
            n++;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_point: write (49,10) not seen within %0d cycles", FRAME); end
        rst = 1'b1;
        @(negedge ppu_clk);
        checks++;
        if ({ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI, vblank, frame_done, frame_cnt, busy} !== 34'd0) begin
            errors++; $display("FAIL rst_outputs: got we=%b x=%0d y=%0d di=%h vb=%b fd=%b cnt=%0d busy=%b required all 0",
                               ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI, vblank, frame_done, frame_cnt, busy);
        end
        checks++;
        if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d required IDLE", dbg_state); end
        tick();
        rst = 1'b0;
        clear_mon();
        repeat (FRAME) tick();
        checks++;
        if (wr_q.size() != 0 || fd_cnt != 0) begin
            errors++; $display("FAIL rst_quiet: got %0d writes %0d frame_done required 0 0", wr_q.size(), fd_cnt);
        end
        clear_mon();
        pattern_sel = 2'd0; cont = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        @(negedge ppu_clk);
        checks++;
        if ({ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI} !== {1'b1, 8'd0, 8'd0, 6'h21}) begin
            errors++; $display("FAIL rst_restart: got we=%b (%0d,%0d) di=%h required 1 (0,0) 21",
                               ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI);
        end
        tick();
        wait_idle(FRAME + 100, "rst_restart_end");
        checks++;
        if (frame_cnt !== 8'd1 || wr_q.size() != WRITES) begin
            errors++; $display("FAIL rst_restart_frame: got cnt=%0d writes=%0d required 1 %0d", frame_cnt, wr_q.size(), WRITES);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        int n;
        do_reset();
        clear_mon();
        t_cont = 1'b1; t_pat = 2'($urandom_range(0, 3)); t_start = 1'b1;
        tick(); t_start = 1'b0;
        n = 0;
        while (t_fd_cnt < 256 && n < 300 * T_FRAME) begin tick(); n++; end
        checks++;
        if (t_fd_cnt != 256) begin errors++; $display("FAIL wrap_frames: got %0d frame_done required 256", t_fd_cnt); end
        checks++;
        if (t_frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_pre: got %0d required 255", t_frame_cnt); end
        t_cont = 1'b0;
        n = 0;
        while (t_busy === 1'b1 && n < 2 * T_FRAME) begin tick(); n++; end
        checks++;
        if (t_busy !== 1'b0) begin errors++; $display("FAIL wrap_stop: busy=%b required 0", t_busy); end
        checks++;
        if (t_frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_post: got %0d required 0", t_frame_cnt); end
        checks++;
        if (t_wr_cnt != 256 * T_HV * T_VV) begin
            errors++; $display("FAIL wrap_writes: got %0d required %0d", t_wr_cnt, 256 * T_HV * T_VV);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_solid_frame();
        test_bars_fb();
        test_stall();
        test_cont_frames();
        test_reset_mid_frame();
        test_frame_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
